uart_tx_framer: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_fifo_buf.sv | 71 +++++++
 rtl/uart_tx_framer.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_framer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state type, default frame/FIFO sizes, line idle level.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;
  localparam logic        LINE_IDLE       = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;
`endif

endpackage

// File: rtl/uart_tx_fifo_buf.sv
// Synchronous circular byte FIFO with registered full/almost_full/empty/level flags and an
// overflow pulse; pointers carry one extra wrap bit so occupancy is their difference.
module uart_tx_fifo_buf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [DATA_W-1:0]        din_i,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        dout_o,
  output logic                     full_o,
  output logic                     almost_full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              full_q, almost_full_q, empty_q, overflow_q;
  logic              push, pop;

  // A write while full is dropped even if a pop frees a slot on the same edge.
  always_comb begin
    push     = wr_en_i && !full_q;
    pop      = rd_en_i && !empty_q;
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    level_d  = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      empty_q       <= 1'b1;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      full_q        <= (level_d == (AW+1)'(DEPTH));
      almost_full_q <= (level_d >= (AW+1)'(DEPTH - 1));
      empty_q       <= (level_d == '0);
      overflow_q    <= wr_en_i && full_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

  assign dout_o        = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o        = full_q;
  assign almost_full_o = almost_full_q;
  assign empty_o       = empty_q;
  assign level_o       = level_q;
  assign overflow_o    = overflow_q;

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: byte FIFO feeding an 8N1 serialiser advanced by the tx_en baud strobe.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned FIFO_DEPTH = UART_FIFO_DEPTH,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic                          tx_en,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          din,
  output logic                          full,
  output logic                          almost_full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx_serial_data
);

  localparam int unsigned CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 line_q, line_d;
  logic                 busy_q, busy_d;
  logic                 pop;
  logic [DATA_BITS-1:0] head;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_tx_fifo_buf #(
    .DATA_W (DATA_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i         (clk_in),
    .rst_ni        (rst_n),
    .wr_en_i       (wr_en),
    .din_i         (din),
    .rd_en_i       (pop),
    .dout_o        (head),
    .full_o        (full),
    .almost_full_o (almost_full),
    .empty_o       (empty),
    .level_o       (level),
    .overflow_o    (overflow)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    line_d     = line_q;
    busy_d     = busy_q;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    if (tx_en) begin
      case (state_q)
        ST_IDLE: begin
          line_d = LINE_IDLE;
          if (!empty) begin
            pop       = 1'b1;
            shreg_d   = head;
            bit_cnt_d = '0;
            line_d    = ~LINE_IDLE;
            busy_d    = 1'b1;
            state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^head;
`endif
          end
        end
        ST_START: begin
          line_d  = shreg_q[0];
          shreg_d = shreg_q >> 1;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            line_d     = parity_q;
            state_d    = ST_PARITY;
`else
            line_d     = LINE_IDLE;
            stop_cnt_d = 1'b0;
            state_d    = ST_STOP;
`endif
          end else begin
            line_d    = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          line_d     = LINE_IDLE;
          stop_cnt_d = 1'b0;
          state_d    = ST_STOP;
        end
`endif
        ST_STOP: begin
          // The strobe ending the last stop bit may launch the next start bit directly.
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            if (!empty) begin
              pop       = 1'b1;
              shreg_d   = head;
              bit_cnt_d = '0;
              line_d    = ~LINE_IDLE;
              state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
              parity_d  = ^head;
`endif
            end else begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: begin
          line_d  = LINE_IDLE;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      line_q     <= LINE_IDLE;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      line_q     <= line_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx_serial_data = line_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer: queue-based frame model checked every cycle,
// plus hand-computed line sequences. Honours UART_TX_PARITY_EN when defined.
module tb_uart_tx_framer;

  localparam int DEPTH = 16;
  localparam int STOPB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic       tx_en  = 1'b0;
  logic       wr_en  = 1'b0;
  logic [7:0] din    = '0;
  logic       full, almost_full, empty, overflow, busy, tx_serial_data;
  logic [4:0] level;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_framer dut (
    .clk_in         (clk_in),
    .rst_n          (rst_n),
    .tx_en          (tx_en),
    .wr_en          (wr_en),
    .din            (din),
    .full           (full),
    .almost_full    (almost_full),
    .empty          (empty),
    .level          (level),
    .overflow       (overflow),
    .busy           (busy),
    .tx_serial_data (tx_serial_data)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: byte queue for the FIFO, bit queue for the frame currently on the line.
  logic [7:0] fifo_m[$];
  logic       bits_m[$];
  logic       m_line = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_ovf  = 1'b0;

  always @(posedge clk_in or negedge rst_n) begin : model
    int         sz0;
    logic [7:0] b;
    if (!rst_n) begin
      fifo_m.delete();
      bits_m.delete();
      m_line = 1'b1;
      m_busy = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      sz0   = fifo_m.size();
      m_ovf = wr_en && (sz0 == DEPTH);
      if (tx_en) begin
        if (bits_m.size() == 0 && sz0 > 0) begin
          b = fifo_m.pop_front();
          bits_m.push_back(1'b0);
          for (int i = 0; i < 8; i++) bits_m.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
          bits_m.push_back(^b);
`endif
          for (int s = 0; s < STOPB; s++) bits_m.push_back(1'b1);
          m_busy = 1'b1;
        end
        if (bits_m.size() > 0) m_line = bits_m.pop_front();
        else begin
          m_line = 1'b1;
          m_busy = 1'b0;
        end
      end
      if (wr_en && sz0 < DEPTH) fifo_m.push_back(din);
    end
  end

  always @(negedge clk_in) begin
    check("line",        tx_serial_data, m_line);
    check("busy",        busy,           m_busy);
    check("overflow",    overflow,       m_ovf);
    check("empty",       empty,          fifo_m.size() == 0);
    check("full",        full,           fifo_m.size() == DEPTH);
    check("almost_full", almost_full,    fifo_m.size() >= DEPTH - 1);
    check("level",       level,          fifo_m.size());
  end

  // Called at a negedge; returns the line level seen one cycle after the strobe.
  task automatic strobe(output logic ln);
    tx_en = 1'b1;
    @(negedge clk_in);
    tx_en = 1'b0;
    ln = tx_serial_data;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    din   = b;
    @(negedge clk_in);
    wr_en = 1'b0;
  endtask

  // exp is written last-bit-first: exp[i] is the level after strobe i.
  task automatic capture(input string nm, input int n, input logic [15:0] exp);
    logic ln;
    for (int i = 0; i < n; i++) begin
      strobe(ln);
      check($sformatf("%s bit%0d", nm, i), ln, exp[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ln;
    repeat (3) @(negedge clk_in);
    #2 rst_n = 1'b1;
    @(negedge clk_in);

    // Idle: strobes with nothing queued keep the line high.
    for (int i = 0; i < 20; i++) begin
      strobe(ln);
      check("idle line", ln, 1'b1);
    end
    check("idle busy", busy, 1'b0);
    check("idle empty", empty, 1'b1);
    check("idle level", level, 0);

    // Single frame 8'hA5.
    push(8'hA5);
    check("A5 level", level, 1);
`ifdef UART_TX_PARITY_EN
    capture("A5", FRAME, 16'b10101001010);
`else
    capture("A5", FRAME, 16'b1101001010);
`endif
    check("A5 busy in stop", busy, 1'b1);
    strobe(ln);
    check("A5 busy after stop", busy, 1'b0);
    check("A5 line after stop", ln, 1'b1);

    // Strobe coincident with the write into an empty FIFO must not launch.
    wr_en = 1'b1; din = 8'h5A; tx_en = 1'b1;
    @(negedge clk_in);
    wr_en = 1'b0; tx_en = 1'b0;
    check("same-cycle line", tx_serial_data, 1'b1);
    check("same-cycle busy", busy, 1'b0);
    check("same-cycle level", level, 1);
    strobe(ln);
    check("5A start", ln, 1'b0);
    for (int i = 0; i < FRAME; i++) strobe(ln);
    check("5A done busy", busy, 1'b0);

    // Three back-to-back frames.
    wr_en = 1'b1;
    din = 8'h00; @(negedge clk_in);
    din = 8'hFF; @(negedge clk_in);
    din = 8'h3C; @(negedge clk_in);
    wr_en = 1'b0;
    check("b2b level", level, 3);
    for (int i = 0; i <= 3 * FRAME; i++) begin
      strobe(ln);
      if (i == FRAME - 1)  check("b2b stop0", ln, 1'b1);
      if (i == FRAME)      check("b2b start1", ln, 1'b0);
      if (i == 2 * FRAME) begin
        check("b2b start2", ln, 1'b0);
        check("b2b empty after 3rd pop", empty, 1'b1);
      end
      if (i == 2 * FRAME + 3) check("b2b 3C bit2", ln, 1'b1);
    end
    check("b2b idle busy", busy, 1'b0);

    // Fill past capacity without strobes.
    for (int i = 0; i < 17; i++) begin
      push(8'(i + 1));
      if (i == 13) check("fill af at 14", almost_full, 1'b0);
      if (i == 14) begin
        check("fill af at 15", almost_full, 1'b1);
        check("fill full at 15", full, 1'b0);
      end
      if (i == 15) begin
        check("fill full at 16", full, 1'b1);
        check("fill ovf at 16", overflow, 1'b0);
      end
      if (i == 16) begin
        check("fill ovf at 17", overflow, 1'b1);
        check("fill level at 17", level, 16);
      end
    end
    @(negedge clk_in);
    check("ovf single pulse", overflow, 1'b0);
    check("level still 16", level, 16);

    // Reset mid-frame: queued 0x55 is aborted while in its data bits.
    #2 rst_n = 1'b0;
    @(negedge clk_in);
    #2 rst_n = 1'b1;
    @(negedge clk_in);
    push(8'h55);
    push(8'hAA);
    for (int i = 0; i < 4; i++) strobe(ln);
    check("55 mid-data bit2", ln, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst line async", tx_serial_data, 1'b1);
    check("rst busy async", busy, 1'b0);
    check("rst level async", level, 0);
    check("rst empty async", empty, 1'b1);
    @(negedge clk_in);
    #2 rst_n = 1'b1;
    @(negedge clk_in);
    push(8'h81);
`ifdef UART_TX_PARITY_EN
    capture("81", FRAME, 16'b10100000010);
`else
    capture("81", FRAME, 16'b1100000010);
`endif
    strobe(ln);
    check("81 busy after", busy, 1'b0);

`ifdef UART_TX_PARITY_EN
    push(8'h07);
    capture("07", FRAME, 16'b11000001110);
    check("07 busy at 11", busy, 1'b1);
    strobe(ln);
    check("07 busy after 12", busy, 1'b0);
    push(8'h03);
    capture("03", FRAME, 16'b10000000110);
    strobe(ln);
    check("03 busy after", busy, 1'b0);
`endif

    repeat (3) @(negedge clk_in);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
